// File: rtl/ppu_pkg.sv
// Shared PPU palette types: CGRAM address/colour types, dot-phase encoding
// and the phase-advance helper used by the CGRAM access arbiter.
package ppu_pkg;

    localparam int CGRAM_ADDR_W   = 8;
    localparam int CGRAM_COLOR_W  = 15;
    localparam int CGRAM_DOT_CLKS = 4;

    typedef logic [CGRAM_ADDR_W-1:0]  cgram_addr_type;
    typedef logic [CGRAM_COLOR_W-1:0] color_type;

    // One dot is four clocks: main lookup, sub lookup, CPU slot, spare.
    typedef enum logic [1:0] {
        PH_MAIN  = 2'd0,
        PH_SUB   = 2'd1,
        PH_CPU   = 2'd2,
        PH_SPARE = 2'd3
    } dot_phase_type;

    // Advance the dot phase, wrapping after the last clock of the dot.
    function automatic dot_phase_type next_phase(input dot_phase_type ph);
        if (int'(ph) == CGRAM_DOT_CLKS - 1) begin
            return PH_MAIN;
        end
        return dot_phase_type'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/cgram_cpu_port.sv
// CPU side of the palette RAM: $2121 address, $2122 byte-pair writes,
// $213B byte-pair reads through a prefetch buffer. Holds the shared byte
// flip-flop, the low-byte latch, the word address and the pending flags,
// and presents one request per CPU slot to the arbiter.
module cgram_cpu_port
    import ppu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int COLOR_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_addr_we,
    input  logic               cpu_data_we,
    input  logic               cpu_data_re,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    input  logic               cpu_slot,
    input  logic [COLOR_W-1:0] cg_rdata,
    output logic               req_we,
    output logic               req_fetch,
    output logic [ADDR_W-1:0]  req_addr,
    output logic [COLOR_W-1:0] req_wdata
);

    logic               flip;
    logic [7:0]         low_latch;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [COLOR_W-1:0] read_buf;
    logic               wr_pend;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_word;
    logic               fetch_pend;
    logic               fetch_issued;
    logic [15:0]        buf_ext;

    // Read data: low byte first, then the high byte with bit 7 forced to 0.
    assign buf_ext   = 16'(read_buf);
    assign cpu_rdata = flip ? buf_ext[15:8] : buf_ext[7:0];

    // Pick this slot's request: a pending write beats a pending fetch.
    always_comb begin
        // NOTE: every output gets a default first; a path that leaves one unassigned would infer a latch.
        req_we    = 1'b0;
        req_fetch = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        if (cpu_slot) begin
            if (wr_pend) begin
                req_we    = 1'b1;
                req_addr  = wr_addr;
                req_wdata = wr_word;
            end else if (fetch_pend) begin
                req_fetch = 1'b1;
                req_addr  = cpu_addr;
            end
        end
    end

    // Slot bookkeeping, prefetch capture and CPU strobe handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip         <= 1'b0;
            low_latch    <= '0;
            cpu_addr     <= '0;
            read_buf     <= '0;
            wr_pend      <= 1'b0;
            wr_addr      <= '0;
            wr_word      <= '0;
            fetch_pend   <= 1'b0;
            fetch_issued <= 1'b0;
        end else begin
            // RAM data for a fetch arrives one clock after the address.
            fetch_issued <= req_fetch;
            if (fetch_issued) begin
                read_buf <= cg_rdata;
            end

            // A finished write is followed by a refetch at the (already
            // advanced) CPU address so the buffer never holds stale data.
            if (req_we) begin
                wr_pend    <= 1'b0;
                fetch_pend <= 1'b1;
            end else if (req_fetch) begin
                fetch_pend <= 1'b0;
            end

            // NOTE: strobe handling sits after the slot updates so a flag set by a strobe overrides a same-clock clear (the last non-blocking assignment wins).
            if (cpu_addr_we) begin
                cpu_addr   <= ADDR_W'(cpu_wdata);
                flip       <= 1'b0;
                fetch_pend <= 1'b1;
            end else if (cpu_data_we) begin
                if (!flip) begin
                    low_latch <= cpu_wdata;
                    flip      <= 1'b1;
                end else begin
                    // Bit 7 of the high byte falls off the 15-bit word.
                    wr_word  <= COLOR_W'({cpu_wdata, low_latch});
                    wr_addr  <= cpu_addr;
                    wr_pend  <= 1'b1;
                    cpu_addr <= cpu_addr + ADDR_W'(1);
                    flip     <= 1'b0;
                end
            end else if (cpu_data_re) begin
                if (!flip) begin
                    flip <= 1'b1;
                end else begin
                    cpu_addr   <= cpu_addr + ADDR_W'(1);
                    flip       <= 1'b0;
                    fetch_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cgram_access_arbiter.sv
// Palette RAM arbiter: time-shares the single-port CGRAM over a fixed
// 4-clock dot between the main-screen lookup, the sub-screen lookup and
// one CPU access, and presents both looked-up colours once per dot.
module cgram_access_arbiter
    import ppu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int COLOR_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic [ADDR_W-1:0]  main_idx,
    input  logic [ADDR_W-1:0]  sub_idx,
    output logic [COLOR_W-1:0] main_color,
    output logic [COLOR_W-1:0] sub_color,
    output logic               pix_valid,
    input  logic               cpu_addr_we,
    input  logic               cpu_data_we,
    input  logic               cpu_data_re,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic [ADDR_W-1:0]  cg_addr,
    output logic [COLOR_W-1:0] cg_wdata,
    output logic               cg_we,
    input  logic [COLOR_W-1:0] cg_rdata
);

    dot_phase_type      phase;
    dot_phase_type      phase_next;
    logic [ADDR_W-1:0]  sub_idx_r;
    logic [COLOR_W-1:0] main_cap;
    logic               req_we;
    logic               req_fetch;
    logic [ADDR_W-1:0]  req_addr;
    logic [COLOR_W-1:0] req_wdata;

    cgram_cpu_port #(
        .ADDR_W  (ADDR_W),
        .COLOR_W (COLOR_W)
    ) u_cpu_port (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr_we (cpu_addr_we),
        .cpu_data_we (cpu_data_we),
        .cpu_data_re (cpu_data_re),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_slot    (phase == PH_CPU),
        .cg_rdata    (cg_rdata),
        .req_we      (req_we),
        .req_fetch   (req_fetch),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata)
    );

    // Dot phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PH_MAIN;
        end else begin
            phase <= phase_next;
        end
    end

    // Next phase: line_start realigns the dot and beats the increment.
    always_comb begin
        phase_next = next_phase(phase);
        if (line_start) begin
            phase_next = PH_MAIN;
        end
    end

    // CGRAM port mux: main index live at phase 0, registered sub index at
    // phase 1, the CPU request at phase 2, idle at phase 3.
    always_comb begin
        cg_addr  = '0;
        cg_wdata = '0;
        cg_we    = 1'b0;
        case (phase)
            PH_MAIN: cg_addr = main_idx;
            PH_SUB:  cg_addr = sub_idx_r;
            PH_CPU: begin
                cg_addr  = req_addr;
                cg_wdata = req_wdata;
                cg_we    = req_we;
            end
            default: ;
        endcase
    end

    // Colour pipeline: main data returns in phase 1, sub data in phase 2;
    // both outputs update together so they are visible, with pix_valid,
    // throughout phase 3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_idx_r  <= '0;
            main_cap   <= '0;
            main_color <= '0;
            sub_color  <= '0;
            pix_valid  <= 1'b0;
        end else begin
            pix_valid <= (phase == PH_CPU) && !line_start;
            case (phase)
                PH_MAIN: sub_idx_r <= sub_idx;
                PH_SUB:  main_cap  <= cg_rdata;
                PH_CPU: begin
                    main_color <= main_cap;
                    sub_color  <= cg_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cgram_access_arbiter.sv
// Self-checking bench for cgram_access_arbiter: behavioural CGRAM stub,
// a reference model of the CPU port and palette contents, and randomized
// plus directed scenarios.
module tb_cgram_access_arbiter;

    logic        clk;
    logic        reset;
    logic        line_start;
    logic [7:0]  main_idx;
    logic [7:0]  sub_idx;
    logic [14:0] main_color;
    logic [14:0] sub_color;
    logic        pix_valid;
    logic        cpu_addr_we;
    logic        cpu_data_we;
    logic        cpu_data_re;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [7:0]  cg_addr;
    logic [14:0] cg_wdata;
    logic        cg_we;
    logic [14:0] cg_rdata;

    int checks = 0;
    int errors = 0;

    // Dot phase the schedule says the current clock belongs to.
    int tb_phase;

    // CGRAM macro stand-in and the reference palette contents.
    logic [14:0] ram [0:255];
    logic [14:0] ram_rd;
    logic [14:0] model_mem [0:255];

    // Reference CPU-port state.
    logic [7:0]  ref_addr;
    logic        ref_flip;
    logic [7:0]  ref_low;
    logic [14:0] ref_buf;
    logic [22:0] exp_wr [$];
    logic [22:0] exp_item;

    int          we_count = 0;
    logic [7:0]  last_we_addr;
    logic [14:0] last_we_data;

    cgram_access_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .main_idx    (main_idx),
        .sub_idx     (sub_idx),
        .main_color  (main_color),
        .sub_color   (sub_color),
        .pix_valid   (pix_valid),
        .cpu_addr_we (cpu_addr_we),
        .cpu_data_we (cpu_data_we),
        .cpu_data_re (cpu_data_re),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cg_addr     (cg_addr),
        .cg_wdata    (cg_wdata),
        .cg_we       (cg_we),
        .cg_rdata    (cg_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one clock read latency.
    always @(posedge clk) begin
        ram_rd = ram[cg_addr];
        if (cg_we) ram[cg_addr] = cg_wdata;
        cg_rdata <= ram_rd;
    end

    // Expected schedule position.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_phase <= 0;
        else       tb_phase <= line_start ? 0 : (tb_phase + 1) % 4;
    end

    // Every RAM write must fall in the CPU slot and match the next expected write.
    always @(negedge clk) begin
        if (!reset && cg_we) begin
            we_count++;
            last_we_addr = cg_addr;
            last_we_data = cg_wdata;
            checks++;
            if (tb_phase != 2) begin
                errors++;
                $display("FAIL we_phase: cg_we at phase %0d, required 2", tb_phase);
            end
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL we_unexpected: addr %h data %h, required no write", cg_addr, cg_wdata);
            end else begin
                exp_item = exp_wr.pop_front();
                if ({cg_addr, cg_wdata} !== exp_item) begin
                    errors++;
                    $display("FAIL we_content: addr %h data %h, required addr %h data %h",
                             cg_addr, cg_wdata, exp_item[22:15], exp_item[14:0]);
                end
            end
        end
    end

    // pix_valid is high exactly in the last clock of each dot.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (pix_valid !== (tb_phase == 3)) begin
                errors++;
                $display("FAIL pix_valid_timing: got %b at phase %0d", pix_valid, tb_phase);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat (12) tick();
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8 && tb_phase != p; i++) tick();
        if (tb_phase != p) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: phase %0d, required %0d", tb_phase, p);
        end
    endtask

    task automatic model_reset();
        ref_addr = 8'h00;
        ref_flip = 1'b0;
        ref_low  = 8'h00;
        ref_buf  = 15'h0000;
        exp_wr.delete();
    endtask

    task automatic do_addr_write(input logic [7:0] v);
        cpu_wdata   = v;
        cpu_addr_we = 1'b1;
        tick();
        cpu_addr_we = 1'b0;
        ref_addr = v;
        ref_flip = 1'b0;
        ref_buf  = model_mem[v];
    endtask

    task automatic do_data_write(input logic [7:0] v);
        logic [14:0] w;
        cpu_wdata   = v;
        cpu_data_we = 1'b1;
        if (ref_flip) begin
            w = {v[6:0], ref_low};
            model_mem[ref_addr] = w;
            exp_wr.push_back({ref_addr, w});
            ref_addr = ref_addr + 8'd1;
            ref_flip = 1'b0;
            ref_buf  = model_mem[ref_addr];
        end else begin
            ref_low  = v;
            ref_flip = 1'b1;
        end
        tick();
        cpu_data_we = 1'b0;
    endtask

    task automatic do_read(input string name, output logic [7:0] got);
        logic [7:0] exp;
        exp = ref_flip ? {1'b0, ref_buf[14:8]} : ref_buf[7:0];
        cpu_data_re = 1'b1;
        @(negedge clk);
        got = cpu_rdata;
        checks++;
        if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL %s: cpu_rdata %h, required %h", name, cpu_rdata, exp);
        end
        tick();
        cpu_data_re = 1'b0;
        if (ref_flip) begin
            ref_addr = ref_addr + 8'd1;
            ref_flip = 1'b0;
            ref_buf  = model_mem[ref_addr];
        end else begin
            ref_flip = 1'b1;
        end
    endtask

    task automatic run_lookup(input string name, input logic [7:0] m, input logic [7:0] s);
        wait_phase(0);
        main_idx = m;
        sub_idx  = s;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: pix_valid %b, required 1", name, pix_valid);
        end
        checks++;
        if (main_color !== model_mem[m]) begin
            errors++;
            $display("FAIL %s_main: idx %h got %h, required %h", name, m, main_color, model_mem[m]);
        end
        checks++;
        if (sub_color !== model_mem[s]) begin
            errors++;
            $display("FAIL %s_sub: idx %h got %h, required %h", name, s, sub_color, model_mem[s]);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (main_color !== 15'h0) begin errors++; $display("FAIL reset_main_color: %h, required 0", main_color); end
        checks++; if (sub_color  !== 15'h0) begin errors++; $display("FAIL reset_sub_color: %h, required 0", sub_color); end
        checks++; if (pix_valid  !== 1'b0)  begin errors++; $display("FAIL reset_pix_valid: %b, required 0", pix_valid); end
        checks++; if (cpu_rdata  !== 8'h0)  begin errors++; $display("FAIL reset_cpu_rdata: %h, required 0", cpu_rdata); end
        checks++; if (cg_addr    !== 8'h0)  begin errors++; $display("FAIL reset_cg_addr: %h, required 0", cg_addr); end
        checks++; if (cg_wdata   !== 15'h0) begin errors++; $display("FAIL reset_cg_wdata: %h, required 0", cg_wdata); end
        checks++; if (cg_we      !== 1'b0)  begin errors++; $display("FAIL reset_cg_we: %b, required 0", cg_we); end
        tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_lookup();
        run_lookup("lookup_basic", 8'h12, 8'h34);
        checks++;
        if ({main_color, sub_color} !== {15'h7C1F, 15'h03E0}) begin
            errors++;
            $display("FAIL lookup_const: %h/%h, required 7c1f/03e0", main_color, sub_color);
        end
    endtask

    task automatic test_random_lookup();
        for (int i = 0; i < 24; i++) begin
            run_lookup("lookup_rand", 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_write_wrap();
        int we_before;
        logic [7:0] got;
        do_addr_write(8'hFF); gap();
        we_before = we_count;
        do_data_write(8'h1F); gap();
        do_data_write(8'hFC); gap();
        checks++;
        if (we_count - we_before != 1) begin
            errors++;
            $display("FAIL wrap_we_count: %0d pulses, required 1", we_count - we_before);
        end
        checks++;
        if ({last_we_addr, last_we_data} !== {8'hFF, 15'h7C1F}) begin
            errors++;
            $display("FAIL wrap_we_word: addr %h data %h, required ff 7c1f", last_we_addr, last_we_data);
        end
        // Low byte of word 0 proves the address wrapped to 0x00.
        do_read("wrap_read_addr0", got); gap();
        run_lookup("wrap_lookup", 8'hFF, 8'h00);
    endtask

    task automatic test_read_prefetch();
        logic [7:0] got;
        do_addr_write(8'h05); gap();
        do_read("prefetch_lo", got); gap();
        checks++;
        if (got !== 8'h34) begin errors++; $display("FAIL prefetch_lo_const: %h, required 34", got); end
        do_read("prefetch_hi", got); gap();
        checks++;
        if (got !== 8'h12) begin errors++; $display("FAIL prefetch_hi_const: %h, required 12", got); end
        do_read("prefetch_next_lo", got); gap();
    endtask

    task automatic test_flip_reset();
        int we_before;
        do_addr_write(8'h08); gap();
        we_before = we_count;
        do_data_write(8'hAA); gap();
        do_addr_write(8'h10); gap();
        do_data_write(8'h55); gap();
        checks++;
        if (we_count != we_before) begin
            errors++;
            $display("FAIL flip_reset_no_we: %0d pulses, required 0", we_count - we_before);
        end
        do_data_write(8'h66); gap();
        checks++;
        if ({last_we_addr, last_we_data} !== {8'h10, 15'h6655}) begin
            errors++;
            $display("FAIL flip_reset_commit: addr %h data %h, required 10 6655", last_we_addr, last_we_data);
        end
        run_lookup("flip_reset_lookup", 8'h10, 8'h11);
    endtask

    task automatic test_line_start();
        int first;
        main_idx = 8'h34;
        sub_idx  = 8'h12;
        wait_phase(2);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pix_valid === 1'b1) begin
                first = i;
                break;
            end
            tick();
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL line_start_latency: pix_valid after %0d clocks, required 3", first);
        end
        checks++;
        if ({main_color, sub_color} !== {model_mem[8'h34], model_mem[8'h12]}) begin
            errors++;
            $display("FAIL line_start_colors: %h/%h, required %h/%h",
                     main_color, sub_color, model_mem[8'h34], model_mem[8'h12]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        do_addr_write(8'h30); gap();
        // Two commits before the CPU slot: only the second survives, at 0x31.
        wait_phase(2);
        for (int i = 0; i < 4; i++) begin
            cpu_wdata   = bytes[i];
            cpu_data_we = 1'b1;
            tick();
        end
        cpu_data_we = 1'b0;
        model_mem[8'h31] = 15'h4433;
        exp_wr.push_back({8'h31, 15'h4433});
        ref_addr = 8'h32;
        ref_flip = 1'b0;
        ref_low  = 8'h33;
        ref_buf  = model_mem[8'h32];
        gap(); gap();
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL b2b_write_missing: %0d writes outstanding, required 0", exp_wr.size());
        end
        run_lookup("b2b_lookup", 8'h30, 8'h31);
    endtask

    task automatic test_random_cpu();
        logic [7:0] v;
        logic [7:0] got;
        int op;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                v = 8'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) v = v + 8'hF8;
                do_addr_write(v);
            end else if (op < 6) begin
                do_data_write(8'($urandom));
            end else begin
                do_read("rand_read", got);
            end
            gap();
        end
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL rand_write_missing: %0d writes outstanding, required 0", exp_wr.size());
        end
        for (int i = 0; i < 8; i++) begin
            run_lookup("rand_cpu_lookup", 8'($urandom_range(0, 7)), 8'($urandom_range(248, 255)));
        end
    endtask

    task automatic test_reset_midop();
        int we_before;
        logic [7:0] got;
        do_addr_write(8'h20); gap();
        do_data_write(8'h11); gap();
        // Second byte lands at the end of phase 3; reset hits before phase 2.
        wait_phase(3);
        cpu_wdata   = 8'h22;
        cpu_data_we = 1'b1;
        tick();
        cpu_data_we = 1'b0;
        main_idx = 8'h00;
        sub_idx  = 8'h00;
        reset    = 1'b1;
        we_before = we_count;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({main_color, sub_color, pix_valid, cpu_rdata, cg_addr, cg_wdata, cg_we} !== 63'h0) begin
            errors++;
            $display("FAIL midop_outputs: %h %h %b %h %h %h %b, required all 0",
                     main_color, sub_color, pix_valid, cpu_rdata, cg_addr, cg_wdata, cg_we);
        end
        tick();
        reset = 1'b0;
        model_reset();
        gap(); gap();
        checks++;
        if (we_count != we_before) begin
            errors++;
            $display("FAIL midop_no_we: %0d pulses, required 0", we_count - we_before);
        end
        // Cleared buffer reads as zero; the increment from address 0 exposes word 1.
        do_read("midop_lo", got); gap();
        do_read("midop_hi", got); gap();
        do_read("midop_addr1_lo", got); gap();
        run_lookup("midop_lookup", 8'h20, 8'h21);
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        line_start  = 1'b0;
        main_idx    = 8'h00;
        sub_idx     = 8'h00;
        cpu_addr_we = 1'b0;
        cpu_data_we = 1'b0;
        cpu_data_re = 1'b0;
        cpu_wdata   = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 15'($urandom);
        end
        ram[8'h12] = 15'h7C1F;
        ram[8'h34] = 15'h03E0;
        ram[8'h05] = 15'h1234;
        ram[8'h01] = 15'h2A5B;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = ram[i];
        end
        model_reset();

        test_reset();
        test_lookup();
        test_random_lookup();
        test_write_wrap();
        test_read_prefetch();
        test_flip_reset();
        test_line_start();
        test_back_to_back();
        test_random_cpu();
        test_reset_midop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
